rv64g_l1_probe_responder: RTL and testbench

- Per-core L1-side responder for L2-initiated coherence probes; the other end of the L2 MSHR probe/probe-ack exchange.
- Accepts one TileLink channel-B Probe and looks up the L1 line state.
- Emits ProbeAck or multi-beat ProbeAckData on channel C, then writes back the downgraded line state.
- One probe in flight; sits between the L1 tag/data arrays and the core's TileLink port.

---
 rtl/rv64g_l1_probe_responder.sv | 265 ++++++++++++++++++++++++++
 tb/tb_rv64g_l1_probe_responder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv64g_l1_probe_responder.sv
// rv64g_l1_probe_responder
// L1-side responder for L2-initiated TileLink channel-B Probes. It accepts one
// probe, looks up the line state in the L1 tag array, and answers on channel C.
// The answer is a single-beat ProbeAck, or a BEATS-beat ProbeAckData when a
// Dirty line is downgraded. It then writes the downgraded state back to the tag
// array. Only one probe is in flight at a time.
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   b_valid_i/b_ready_o            Probe handshake; b_addr_i, b_param_i (cap), b_source_i
//   lookup_req_o/lookup_addr_o     tag lookup request
//   lookup_valid_i/hit_i/state_i   tag lookup result (state: 0 N, 1 B, 2 T, 3 Dirty)
//   data_rd_o/data_beat_o          data array read; data_rdata_i valid the cycle after
//   c_valid_o/c_ready_i            channel-C handshake; c_opcode_o, c_param_o,
//                                  c_source_o, c_addr_o, c_data_o, c_last_o
//   update_o/update_state_o        one-cycle tag state writeback
//   busy_o                         FSM not idle
//
// Optional build macro L1_PROBE_STATS_EN adds the probe_cnt_o and dirty_ack_cnt_o
// 32-bit statistics counters.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | ready for a probe
// LOOKUP    | tag lookup outstanding
// RESP      | single-beat ProbeAck on C
// DATA_RD   | read strobe for the current beat
// DATA_SEND | ProbeAckData beat on C
// UPDATE    | one-cycle writeback of the new line state
module rv64g_l1_probe_responder #(
  parameter int ADDR_W   = 64,
  parameter int SOURCE_W = 6,
  parameter int DATA_W   = 64,
  parameter int BEATS    = 8,
  localparam int BEAT_W  = $clog2(BEATS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                b_valid_i,
  output logic                b_ready_o,
  input  logic [ADDR_W-1:0]   b_addr_i,
  input  logic [1:0]          b_param_i,
  input  logic [SOURCE_W-1:0] b_source_i,
  output logic                lookup_req_o,
  output logic [ADDR_W-1:0]   lookup_addr_o,
  input  logic                lookup_valid_i,
  input  logic                lookup_hit_i,
  input  logic [1:0]          lookup_state_i,
  output logic                data_rd_o,
  output logic [BEAT_W-1:0]   data_beat_o,
  input  logic [DATA_W-1:0]   data_rdata_i,
  output logic                c_valid_o,
  input  logic                c_ready_i,
  output logic [2:0]          c_opcode_o,
  output logic [2:0]          c_param_o,
  output logic [SOURCE_W-1:0] c_source_o,
  output logic [ADDR_W-1:0]   c_addr_o,
  output logic [DATA_W-1:0]   c_data_o,
  output logic                c_last_o,
  output logic                update_o,
  output logic [1:0]          update_state_o,
  output logic                busy_o
`ifdef L1_PROBE_STATS_EN
  ,
  output logic [31:0]         probe_cnt_o,
  output logic [31:0]         dirty_ack_cnt_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_RESP, S_DATA_RD, S_DATA_SEND, S_UPDATE
  } state_t;

  localparam logic [1:0] ST_N = 2'd0, ST_B = 2'd1, ST_T = 2'd2, ST_D = 2'd3;
  localparam logic [1:0] CAP_T = 2'd0, CAP_B = 2'd1;
  localparam logic [2:0] P_TTOB = 3'd0, P_TTON = 3'd1, P_BTON = 3'd2,
                         P_TTOT = 3'd3, P_BTOB = 3'd4, P_NTON = 3'd5;
  localparam logic [2:0] OP_ACK = 3'd4, OP_ACK_DATA = 3'd5;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          cap_q, cap_d;
  logic [SOURCE_W-1:0] source_q, source_d;
  logic [2:0]          cparam_q, cparam_d;
  logic [1:0]          new_state_q, new_state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                rd_pend_q, rd_pend_d;

  // Lookup decode: a miss is an N line; cap 3 behaves as toN.
  logic [1:0] lk_state;
  logic [2:0] lk_cparam;
  logic [1:0] lk_new;
  logic       lk_data;

  always_comb begin
    lk_state  = lookup_hit_i ? lookup_state_i : ST_N;
    lk_cparam = P_NTON;
    lk_new    = ST_N;
    lk_data   = 1'b0;
    case (lk_state)
      ST_T, ST_D: begin
        if (cap_q == CAP_T) begin
          lk_cparam = P_TTOT;
          lk_new    = lk_state;
        end else if (cap_q == CAP_B) begin
          lk_cparam = P_TTOB;
          lk_new    = ST_B;
          lk_data   = (lk_state == ST_D);
        end else begin
          lk_cparam = P_TTON;
          lk_new    = ST_N;
          lk_data   = (lk_state == ST_D);
        end
      end
      ST_B: begin
        if (cap_q == CAP_T || cap_q == CAP_B) begin
          lk_cparam = P_BTOB;
          lk_new    = ST_B;
        end else begin
          lk_cparam = P_BTON;
          lk_new    = ST_N;
        end
      end
      default: begin
        lk_cparam = P_NTON;
        lk_new    = ST_N;
      end
    endcase
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    cap_d          = cap_q;
    source_d       = source_q;
    cparam_d       = cparam_q;
    new_state_d    = new_state_q;
    beat_d         = beat_q;
    data_d         = data_q;
    rd_pend_d      = 1'b0;
    b_ready_o      = 1'b0;
    lookup_req_o   = 1'b0;
    lookup_addr_o  = '0;
    data_rd_o      = 1'b0;
    data_beat_o    = '0;
    c_valid_o      = 1'b0;
    c_opcode_o     = '0;
    c_param_o      = '0;
    c_source_o     = '0;
    c_addr_o       = '0;
    c_data_o       = '0;
    c_last_o       = 1'b0;
    update_o       = 1'b0;
    update_state_o = '0;
    busy_o         = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        b_ready_o = 1'b1;
        if (b_valid_i) begin
          addr_d   = b_addr_i;
          cap_d    = b_param_i;
          source_d = b_source_i;
          state_d  = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        lookup_req_o  = 1'b1;
        lookup_addr_o = addr_q;
        if (lookup_valid_i) begin
          cparam_d    = lk_cparam;
          new_state_d = lk_new;
          beat_d      = '0;
          state_d     = lk_data ? S_DATA_RD : S_RESP;
        end
      end
      S_RESP: begin
        c_valid_o  = 1'b1;
        c_opcode_o = OP_ACK;
        c_param_o  = cparam_q;
        c_source_o = source_q;
        c_addr_o   = addr_q;
        c_last_o   = 1'b1;
        if (c_ready_i) state_d = S_UPDATE;
      end
      S_DATA_RD: begin
        data_rd_o   = 1'b1;
        data_beat_o = beat_q;
        rd_pend_d   = 1'b1;
        state_d     = S_DATA_SEND;
      end
      S_DATA_SEND: begin
        // Read data is only guaranteed in the first SEND cycle; hold a copy
        // so a stalled beat stays stable.
        if (rd_pend_q) data_d = data_rdata_i;
        c_valid_o  = 1'b1;
        c_opcode_o = OP_ACK_DATA;
        c_param_o  = cparam_q;
        c_source_o = source_q;
        c_addr_o   = addr_q;
        c_data_o   = rd_pend_q ? data_rdata_i : data_q;
        c_last_o   = (beat_q == LAST_BEAT);
        if (c_ready_i) begin
          if (beat_q == LAST_BEAT) begin
            state_d = S_UPDATE;
          end else begin
            beat_d  = beat_q + BEAT_W'(1);
            state_d = S_DATA_RD;
          end
        end
      end
      S_UPDATE: begin
        update_o       = 1'b1;
        update_state_o = new_state_q;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      cap_q       <= '0;
      source_q    <= '0;
      cparam_q    <= '0;
      new_state_q <= '0;
      beat_q      <= '0;
      data_q      <= '0;
      rd_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cap_q       <= cap_d;
      source_q    <= source_d;
      cparam_q    <= cparam_d;
      new_state_q <= new_state_d;
      beat_q      <= beat_d;
      data_q      <= data_d;
      rd_pend_q   <= rd_pend_d;
    end
  end

`ifdef L1_PROBE_STATS_EN
  logic [31:0] probe_cnt_q, dirty_ack_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      probe_cnt_q     <= '0;
      dirty_ack_cnt_q <= '0;
    end else begin
      if (b_valid_i && b_ready_o) probe_cnt_q <= probe_cnt_q + 32'd1;
      if (state_q == S_DATA_SEND && c_ready_i && beat_q == LAST_BEAT)
        dirty_ack_cnt_q <= dirty_ack_cnt_q + 32'd1;
    end
  end

  assign probe_cnt_o     = probe_cnt_q;
  assign dirty_ack_cnt_o = dirty_ack_cnt_q;
`endif

endmodule

// File: tb/tb_rv64g_l1_probe_responder.sv
module tb_rv64g_l1_probe_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        b_valid_i, b_ready_o;
  logic [63:0] b_addr_i;
  logic [1:0]  b_param_i;
  logic [5:0]  b_source_i;
  logic        lookup_req_o;
  logic [63:0] lookup_addr_o;
  logic        lookup_valid_i, lookup_hit_i;
  logic [1:0]  lookup_state_i;
  logic        data_rd_o;
  logic [2:0]  data_beat_o;
  logic [63:0] data_rdata_i;
  logic        c_valid_o, c_ready_i;
  logic [2:0]  c_opcode_o, c_param_o;
  logic [5:0]  c_source_o;
  logic [63:0] c_addr_o, c_data_o;
  logic        c_last_o, update_o;
  logic [1:0]  update_state_o;
  logic        busy_o;

  always #5 clk = ~clk;

  rv64g_l1_probe_responder dut (
    .clk(clk), .rst_n(rst_n),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_addr_i(b_addr_i),
    .b_param_i(b_param_i), .b_source_i(b_source_i),
    .lookup_req_o(lookup_req_o), .lookup_addr_o(lookup_addr_o),
    .lookup_valid_i(lookup_valid_i), .lookup_hit_i(lookup_hit_i),
    .lookup_state_i(lookup_state_i),
    .data_rd_o(data_rd_o), .data_beat_o(data_beat_o), .data_rdata_i(data_rdata_i),
    .c_valid_o(c_valid_o), .c_ready_i(c_ready_i), .c_opcode_o(c_opcode_o),
    .c_param_o(c_param_o), .c_source_o(c_source_o), .c_addr_o(c_addr_o),
    .c_data_o(c_data_o), .c_last_o(c_last_o),
    .update_o(update_o), .update_state_o(update_state_o), .busy_o(busy_o)
  );

  // Synchronous data array: data valid only in the cycle after the strobe.
  logic [63:0] dbase;
  always @(posedge clk) begin
    if (data_rd_o) data_rdata_i <= dbase + 64'(data_beat_o);
    else           data_rdata_i <= 64'hDEAD_BEEF_0BAD_F00D;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  par;
    logic [5:0]  src;
    logic [63:0] addr;
    logic [63:0] data;
    logic        last;
    int          cyc;
  } beat_t;

  beat_t       beats[$];
  int          acc_cyc[$];
  int          upd_cyc[$];
  int          upd_cnt, rd_cnt;
  logic [1:0]  upd_state;

  always @(negedge clk) begin
    if (rst_n) begin
      if (b_valid_i && b_ready_o) acc_cyc.push_back(cyc);
      if (c_valid_o && c_ready_i)
        beats.push_back('{c_opcode_o, c_param_o, c_source_o, c_addr_o, c_data_o, c_last_o, cyc});
      if (update_o) begin
        upd_cnt++;
        upd_state = update_state_o;
        upd_cyc.push_back(cyc);
      end
      if (data_rd_o) rd_cnt++;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    beats.delete();
    acc_cyc.delete();
    upd_cyc.delete();
    upd_cnt = 0;
    rd_cnt  = 0;
  endtask

  task automatic send_probe(input logic [63:0] a, input logic [1:0] cap, input logic [5:0] src);
    bit done = 0;
    b_addr_i = a; b_param_i = cap; b_source_i = src; b_valid_i = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      if (b_ready_o) done = 1;
      step();
    end
    b_valid_i = 1'b0;
    if (!done) check("probe_accept_timeout", 0, 1);
  endtask

  task automatic wait_update(input int n);
    int k = 0;
    while (upd_cnt < n && k < 200) begin
      step();
      k++;
    end
    if (upd_cnt < n) check("update_timeout", 64'(upd_cnt), 64'(n));
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    b_valid_i = 0; b_addr_i = 0; b_param_i = 0; b_source_i = 0;
    lookup_valid_i = 1; lookup_hit_i = 1; lookup_state_i = 0;
    c_ready_i = 1; dbase = 0; upd_state = 0;
    clear_mon();
    step(2);
    check("rst_b_ready", b_ready_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_c_valid", c_valid_o, 0);
    check("rst_update", update_o, 0);
    check("rst_lookup_req", lookup_req_o, 0);
    check("rst_data_rd", data_rd_o, 0);
    rst_n = 1'b1;
    step();

    // Clean B line probed toN: single ProbeAck BtoN, latency 2/3
    clear_mon();
    lookup_hit_i = 1; lookup_state_i = 2'd1;
    send_probe(64'h1000, 2'd2, 6'h1A);
    wait_update(1);
    check("t1_nbeats", 64'(beats.size()), 1);
    if (beats.size() >= 1 && acc_cyc.size() >= 1 && upd_cyc.size() >= 1) begin
      check("t1_op", beats[0].op, 4);
      check("t1_param", beats[0].par, 2);
      check("t1_src", beats[0].src, 6'h1A);
      check("t1_addr", beats[0].addr, 64'h1000);
      check("t1_data", beats[0].data, 0);
      check("t1_last", beats[0].last, 1);
      check("t1_c_latency", 64'(beats[0].cyc - acc_cyc[0]), 2);
      check("t1_upd_latency", 64'(upd_cyc[0] - acc_cyc[0]), 3);
    end
    check("t1_upd_state", upd_state, 0);
    check("t1_upd_cnt", 64'(upd_cnt), 1);

    // Dirty line probed toB: 8-beat ProbeAckData TtoB
    clear_mon();
    lookup_state_i = 2'd3; dbase = 64'hA0;
    send_probe(64'h2040, 2'd1, 6'h05);
    wait_update(1);
    check("t2_nbeats", 64'(beats.size()), 8);
    for (int i = 0; i < beats.size(); i++) begin
      check($sformatf("t2_op%0d", i), beats[i].op, 5);
      check($sformatf("t2_param%0d", i), beats[i].par, 0);
      check($sformatf("t2_data%0d", i), beats[i].data, 64'hA0 + 64'(i));
      check($sformatf("t2_last%0d", i), beats[i].last, (i == 7) ? 1 : 0);
    end
    check("t2_rd_cnt", 64'(rd_cnt), 8);
    check("t2_upd_state", upd_state, 1);

    // Dirty line probed toT: no data, TtoT, stays Dirty
    clear_mon();
    send_probe(64'h3000, 2'd0, 6'h07);
    wait_update(1);
    check("t3_nbeats", 64'(beats.size()), 1);
    if (beats.size() >= 1) begin
      check("t3_op", beats[0].op, 4);
      check("t3_param", beats[0].par, 3);
      check("t3_last", beats[0].last, 1);
    end
    check("t3_upd_state", upd_state, 3);
    check("t3_rd_cnt", 64'(rd_cnt), 0);

    // Dirty toN with a 3-cycle stall on beat 2
    begin
      bit hit2 = 0;
      clear_mon();
      dbase = 64'hB0;
      send_probe(64'h4000, 2'd2, 6'h2C);
      for (int k = 0; k < 100 && !hit2; k++) begin
        if (beats.size() == 2 && c_valid_o) hit2 = 1;
        else step();
      end
      check("t4_reach_beat2", hit2, 1);
      c_ready_i = 1'b0;
      for (int s = 0; s < 3; s++) begin
        check($sformatf("t4_hold_valid%0d", s), c_valid_o, 1);
        check($sformatf("t4_hold_data%0d", s), c_data_o, 64'hB2);
        check($sformatf("t4_hold_last%0d", s), c_last_o, 0);
        step();
      end
      c_ready_i = 1'b1;
      wait_update(1);
      check("t4_nbeats", 64'(beats.size()), 8);
      for (int i = 0; i < beats.size(); i++) begin
        check($sformatf("t4_data%0d", i), beats[i].data, 64'hB0 + 64'(i));
        check($sformatf("t4_param%0d", i), beats[i].par, 1);
      end
      check("t4_upd_state", upd_state, 0);
    end

    // Back-to-back probes held valid; lookup miss toN gives NtoN
    clear_mon();
    lookup_hit_i = 0; lookup_state_i = 2'd3;
    b_addr_i = 64'h5500; b_param_i = 2'd2; b_source_i = 6'h33; b_valid_i = 1'b1;
    for (int k = 0; k < 60; k++) begin
      step();
      if (acc_cyc.size() >= 2) break;
    end
    b_valid_i = 1'b0;
    wait_update(2);
    check("t5_accepts", 64'(acc_cyc.size()), 2);
    if (acc_cyc.size() >= 2 && upd_cyc.size() >= 1)
      check("t5_next_accept", 64'(acc_cyc[1]), 64'(upd_cyc[0] + 1));
    check("t5_nbeats", 64'(beats.size()), 2);
    if (beats.size() >= 2) begin
      check("t5_param0", beats[0].par, 5);
      check("t5_param1", beats[1].par, 5);
      check("t5_op1", beats[1].op, 4);
    end
    check("t5_upd_state", upd_state, 0);

    // Reset during DATA_SEND of beat 4, then a normal probe
    begin
      bit hit4 = 0;
      clear_mon();
      lookup_hit_i = 1; lookup_state_i = 2'd3; dbase = 64'hC0;
      send_probe(64'h6000, 2'd2, 6'h22);
      for (int k = 0; k < 100 && !hit4; k++) begin
        if (beats.size() == 4 && c_valid_o) hit4 = 1;
        else step();
      end
      check("t6_reach_beat4", hit4, 1);
      rst_n = 1'b0;
      #1;
      check("t6_c_valid", c_valid_o, 0);
      check("t6_busy", busy_o, 0);
      check("t6_b_ready", b_ready_o, 1);
      step(2);
      rst_n = 1'b1;
      step(5);
      check("t6_no_update", 64'(upd_cnt), 0);
      check("t6_beats_frozen", 64'(beats.size()), 4);
      clear_mon();
      lookup_state_i = 2'd2;
      send_probe(64'h7000, 2'd1, 6'h11);
      wait_update(1);
      check("t6_nbeats", 64'(beats.size()), 1);
      if (beats.size() >= 1) begin
        check("t6_op", beats[0].op, 4);
        check("t6_param", beats[0].par, 0);
        check("t6_src", beats[0].src, 6'h11);
      end
      check("t6_upd_state", upd_state, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
